// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks pending writers per register and holds ID on RAW/buffer hazards.
// Latency: stall is combinational; pend/cnt/fwd, pending_cnt and stall_cycles update on the next Clk edge.
// Backpressure: stall holds the ID stage, and a stalled issue request records nothing.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int LW   = 3,
  parameter int SCW  = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          issue_valid,
  input  logic          issue_wen,
  input  logic [AW-1:0] issue_dst,
  input  logic [LW-1:0] issue_lat,
  input  logic          issue_fwd,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic          src_a_use,
  input  logic          src_b_use,
  input  logic          id_fwd,
  input  logic          need_buff,
  input  logic          buf_ready,
  output logic          stall,
  output logic [AW:0]   pending_cnt,
  output logic [SCW-1:0] stall_cycles
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] fwd_q, fwd_d;
  logic [LW-1:0]   cnt_q [NREG];
  logic [LW-1:0]   cnt_d [NREG];
  logic [AW:0]     pending_cnt_q, pending_cnt_d;
  logic [SCW-1:0]  stall_cycles_q, stall_cycles_d;

  logic hit_a, hit_b, accept, wr;

  // Hazard detection; a forwardable producer is invisible to a consumer that can take class forwarding.
  always_comb begin
    hit_a  = src_a_use && (src_a != '0) && pend_q[src_a] && !(fwd_q[src_a] && id_fwd);
    hit_b  = src_b_use && (src_b != '0) && pend_q[src_b] && !(fwd_q[src_b] && id_fwd);
    stall  = hit_a || hit_b || (need_buff && !buf_ready);
    accept = issue_valid && !stall;
    wr     = accept && issue_wen && (issue_dst != '0) && (issue_lat != '0);
  end

  // Per-register next state: an issue write wins over expiry; otherwise pending entries count down.
  always_comb begin
    logic [LW-1:0] cnt_dec;
    pend_d = pend_q;
    fwd_d  = fwd_q;
    for (int r = 0; r < NREG; r++) cnt_d[r] = cnt_q[r];
    cnt_dec = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_dec = cnt_q[r] - 1'b1;
      if (wr && (issue_dst == AW'(r))) begin
        pend_d[r] = 1'b1;
        fwd_d[r]  = issue_fwd;
        // WAW: keep whichever result lands later
        if (pend_q[r] && (cnt_dec > issue_lat)) cnt_d[r] = cnt_dec;
        else                                    cnt_d[r] = issue_lat;
      end else if (pend_q[r]) begin
        cnt_d[r] = cnt_dec;
        if (cnt_q[r] == LW'(1)) begin
          pend_d[r] = 1'b0;
          fwd_d[r]  = 1'b0;
        end
      end
    end
    // register 0 is hardwired and never tracked
    pend_d[0] = 1'b0;
    fwd_d[0]  = 1'b0;
    cnt_d[0]  = '0;
  end

  // Population count of the next pending vector and saturating stall counter.
  always_comb begin
    pending_cnt_d = '0;
    for (int r = 0; r < NREG; r++) pending_cnt_d = pending_cnt_d + (AW+1)'(pend_d[r]);
    stall_cycles_d = stall_cycles_q;
    if (issue_valid && stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // State registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_q         <= '0;
      fwd_q          <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      pending_cnt_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      pend_q         <= pend_d;
      fwd_q          <= fwd_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      pending_cnt_q  <= pending_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pending_cnt  = pending_cnt_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one task per scenario, expected values hand-computed.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 0, issue_wen = 0, issue_fwd = 0;
  logic [4:0] issue_dst = 0, src_a = 0, src_b = 0;
  logic [2:0] issue_lat = 0;
  logic       src_a_use = 0, src_b_use = 0, id_fwd = 0, need_buff = 0, buf_ready = 1;
  logic       stall;
  logic [5:0] pending_cnt;
  logic [15:0] stall_cycles;
  int n_vec = 0;
  int n_err = 0;

  hazard_scoreboard dut (
    .Clk(clk), .Reset(rst),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dst(issue_dst),
    .issue_lat(issue_lat), .issue_fwd(issue_fwd),
    .src_a(src_a), .src_b(src_b), .src_a_use(src_a_use), .src_b_use(src_b_use),
    .id_fwd(id_fwd), .need_buff(need_buff), .buf_ready(buf_ready),
    .stall(stall), .pending_cnt(pending_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wen = 0; issue_dst = 0; issue_lat = 0; issue_fwd = 0;
    src_a = 0; src_b = 0; src_a_use = 0; src_b_use = 0; id_fwd = 0;
    need_buff = 0; buf_ready = 1;
  endtask

  task automatic issue(input logic [4:0] dst, input logic [2:0] lat, input logic fwd);
    idle();
    issue_valid = 1; issue_wen = 1; issue_dst = dst; issue_lat = lat; issue_fwd = fwd;
  endtask

  task automatic test_reset();
    idle();
    src_a = 5; src_a_use = 1;
    #2;
    n_vec++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL reset_pcnt: got %0d want 0", pending_cnt); end
    n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_scyc: got %0d want 0", stall_cycles); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    tick();
    rst = 0;
  endtask

  // r5 lat=3 issued on the first edge after reset; consumer arrives in the second pending cycle
  task automatic test_basic();
    issue(5, 3, 0);
    tick();
    idle();
    #1;
    n_vec++; if (pending_cnt !== 6'd1) begin n_err++; $display("FAIL basic_first_issue: pcnt %0d want 1", pending_cnt); end
    tick();
    idle(); issue_valid = 1; src_a = 5; src_a_use = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL basic_stall_%0d: got %b want 1", i, stall); end
      tick();
    end
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL basic_release: got %b want 0", stall); end
    n_vec++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL basic_pcnt: got %0d want 0", pending_cnt); end
    n_vec++; if (stall_cycles !== 16'd2) begin n_err++; $display("FAIL basic_scyc: got %0d want 2", stall_cycles); end
    tick();
    idle();
  endtask

  task automatic test_fwd();
    issue(7, 4, 1);
    tick();
    idle(); issue_valid = 1; src_b = 7; src_b_use = 1; id_fwd = 1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_ok: got %b want 0", stall); end
    issue_valid = 0; id_fwd = 0;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL fwd_nofwd_c4: got %b want 1", stall); end
    for (int i = 3; i >= 1; i--) begin
      tick(); #1;
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL fwd_nofwd_c%0d: got %b want 1", i, stall); end
    end
    tick(); #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_expiry: got %b want 0", stall); end
    idle();
  endtask

  task automatic test_waw();
    issue(3, 2, 0);
    tick();
    issue(3, 5, 0);
    #1;
    n_vec++; if (pending_cnt !== 6'd1) begin n_err++; $display("FAIL waw_pcnt_pre: got %0d want 1", pending_cnt); end
    tick();
    idle(); src_a = 3; src_a_use = 1;
    for (int i = 5; i >= 1; i--) begin
      #1;
      n_vec++; if (pending_cnt !== 6'd1 || stall !== 1'b1) begin
        n_err++; $display("FAIL waw_hold_c%0d: pcnt %0d stall %b want 1 1", i, pending_cnt, stall);
      end
      tick();
    end
    #1;
    n_vec++; if (pending_cnt !== 6'd0 || stall !== 1'b0) begin
      n_err++; $display("FAIL waw_done: pcnt %0d stall %b want 0 0", pending_cnt, stall);
    end
    idle();
  endtask

  task automatic test_expire_win();
    issue(4, 1, 0);
    tick();
    issue(4, 2, 0);
    tick();
    idle(); src_b = 4; src_b_use = 1;
    #1;
    n_vec++; if (pending_cnt !== 6'd1 || stall !== 1'b1) begin
      n_err++; $display("FAIL expire_win_c2: pcnt %0d stall %b want 1 1", pending_cnt, stall);
    end
    tick(); #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL expire_win_c1: got %b want 1", stall); end
    tick(); #1;
    n_vec++; if (stall !== 1'b0 || pending_cnt !== 6'd0) begin
      n_err++; $display("FAIL expire_win_done: stall %b pcnt %0d want 0 0", stall, pending_cnt);
    end
    idle();
  endtask

  task automatic test_no_stall();
    issue(0, 3, 0);
    tick();
    idle(); src_a = 0; src_a_use = 1;
    #1;
    n_vec++; if (stall !== 1'b0 || pending_cnt !== 6'd0) begin
      n_err++; $display("FAIL r0: stall %b pcnt %0d want 0 0", stall, pending_cnt);
    end
    need_buff = 1; buf_ready = 0;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL buff_wait: got %b want 1", stall); end
    buf_ready = 1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL buff_ready: got %b want 0", stall); end
    issue(6, 0, 0);
    tick();
    idle(); src_a = 6; src_a_use = 1;
    #1;
    n_vec++; if (stall !== 1'b0 || pending_cnt !== 6'd0) begin
      n_err++; $display("FAIL lat0: stall %b pcnt %0d want 0 0", stall, pending_cnt);
    end
    issue(8, 2, 0);
    tick();
    idle(); src_a = 8; src_a_use = 0; src_b = 8; src_b_use = 0;
    #1;
    n_vec++; if (stall !== 1'b0 || pending_cnt !== 6'd1) begin
      n_err++; $display("FAIL use0: stall %b pcnt %0d want 0 1", stall, pending_cnt);
    end
    tick(); tick();
    idle();
  endtask

  // counter starts at 2; 65539 more stalled edges would wrap to 5 without saturation
  task automatic test_saturate();
    idle(); issue_valid = 1; need_buff = 1; buf_ready = 0;
    repeat (65539) tick();
    idle();
    #1;
    n_vec++; if (stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat: got %0d want 65535", stall_cycles); end
    tick(); #1;
    n_vec++; if (stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %0d want 65535", stall_cycles); end
  endtask

  task automatic test_reset_mid();
    issue(9, 6, 0);
    tick();
    idle();
    tick(); tick();
    src_a = 9; src_a_use = 1;
    #1;
    n_vec++; if (stall !== 1'b1 || pending_cnt !== 6'd1) begin
      n_err++; $display("FAIL rstmid_pre: stall %b pcnt %0d want 1 1", stall, pending_cnt);
    end
    #1 rst = 1;
    #1;
    n_vec++; if (stall !== 1'b0 || pending_cnt !== 6'd0 || stall_cycles !== 16'd0) begin
      n_err++; $display("FAIL rstmid_async: stall %b pcnt %0d scyc %0d want 0 0 0", stall, pending_cnt, stall_cycles);
    end
    need_buff = 1; buf_ready = 0;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rstmid_buff: got %b want 1", stall); end
    need_buff = 0; buf_ready = 1;
    tick();
    rst = 0;
    tick(); tick(); #1;
    n_vec++; if (stall !== 1'b0 || pending_cnt !== 6'd0) begin
      n_err++; $display("FAIL rstmid_after: stall %b pcnt %0d want 0 0", stall, pending_cnt);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd();
    test_waw();
    test_expire_win();
    test_no_stall();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
